// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the two requester ports and memory port B for dmem_arbiter.
//
// Handshake (both requesters): a requester raises rX_req with rX_we, rX_addr,
// rX_wdata and rX_be, and holds all of them stable until rX_gnt is high in the
// same cycle. The access completes at the posedge where req & gnt are both 1.
// rX_gnt is combinational. A read returns rX_rvalid/rX_rdata exactly one
// cycle after its grant cycle. A write has no response.
//
// Modports
//   slave  : the arbiter (takes requests and mem_rdata, drives grants,
//            read returns and the memory command).
//   master : the environment (requesters plus the synchronous memory).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // requester 0 (core dmem)
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic [BE_W-1:0]   r0_be;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic [DATA_W-1:0] r0_rdata;

  // requester 1 (boot loader / DMA)
  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic [BE_W-1:0]   r1_be;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] r1_rdata;

  // memory port B
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r0_be,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata, r1_be,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_wdata, mem_be, mem_we,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r0_be,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata, r1_be,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_wdata, mem_be, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares memory port B between requester 0 (core dmem) and requester 1
// (boot loader / DMA). One access per cycle, round-robin with a bounded
// burst: while both request, the last winner keeps the port for at most
// MAX_BURST consecutive grants. The memory command is a combinational mux of
// the winner; read data comes back one cycle after the grant, routed to the
// requester that issued it.
//
// Ports
//   clk    : core clock
//   reset  : asynchronous, active-high reset
//   bus    : dmem_arbiter_if.slave (requester 0/1 ports and memory port B)
//   perf_gnt0/1, perf_wait0/1 (32 bit, only when DMEM_ARB_PERF_EN is defined):
//            grant counts and waiting-cycle counts per requester, wrapping.
//
// Optional feature macro: DMEM_ARB_PERF_EN
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_gnt0,
  output logic [31:0]   perf_gnt1,
  output logic [31:0]   perf_wait0,
  output logic [31:0]   perf_wait1
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // arbiter state
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // read return pipeline
  logic             rpend_q, rpend_d;
  logic             rsel_q, rsel_d;

  // winner of this cycle
  logic              win_valid;
  logic              win_sel;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;

  // Grants are held off while reset is high so nothing can be accepted
  // during reset, even if a requester keeps req asserted.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = 1'b0;
    if (!reset) begin
      if (bus.r0_req && bus.r1_req) begin
        win_valid = 1'b1;
        // burst budget exhausted -> hand the port to the other side
        win_sel   = (cnt_q < MAX_CNT) ? last_q : ~last_q;
      end else if (bus.r0_req) begin
        win_valid = 1'b1;
        win_sel   = 1'b0;
      end else if (bus.r1_req) begin
        win_valid = 1'b1;
        win_sel   = 1'b1;
      end
    end
  end

  // memory command mux; idle command is all zeros
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    if (win_valid) begin
      if (win_sel) begin
        win_we    = bus.r1_we;
        win_addr  = bus.r1_addr;
        win_wdata = bus.r1_wdata;
        win_be    = bus.r1_be;
      end else begin
        win_we    = bus.r0_we;
        win_addr  = bus.r0_addr;
        win_wdata = bus.r0_wdata;
        win_be    = bus.r0_be;
      end
    end
  end

  assign bus.mem_we    = win_we;
  assign bus.mem_addr  = win_addr;
  assign bus.mem_wdata = win_wdata;
  assign bus.mem_be    = win_be;

  assign bus.r0_gnt = win_valid & ~win_sel;
  assign bus.r1_gnt = win_valid &  win_sel;

  // state update: repeat grants saturate at MAX_BURST, a switch restarts at 1
  always_comb begin
    last_d  = last_q;
    cnt_d   = cnt_q;
    rpend_d = win_valid & ~win_we;
    rsel_d  = win_sel;
    if (win_valid) begin
      if (win_sel == last_q) begin
        if (cnt_q < MAX_CNT) begin
          cnt_d = cnt_q + ONE_CNT;
        end
      end else begin
        last_d = win_sel;
        cnt_d  = ONE_CNT;
      end
    end
  end

  // Clearing rpend on reset drops the response of a read granted just
  // before reset, so it never shows up as rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= 1'b0;
      cnt_q   <= '0;
      rpend_q <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
    end
  end

  assign bus.r0_rvalid = rpend_q & ~rsel_q;
  assign bus.r1_rvalid = rpend_q &  rsel_q;
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_rdata : '0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_gnt0_q, perf_gnt1_q, perf_wait0_q, perf_wait1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_wait0_q <= '0;
      perf_wait1_q <= '0;
    end else begin
      if (bus.r0_gnt) perf_gnt0_q <= perf_gnt0_q + 32'd1;
      if (bus.r1_gnt) perf_gnt1_q <= perf_gnt1_q + 32'd1;
      if (bus.r0_req && !bus.r0_gnt) perf_wait0_q <= perf_wait0_q + 32'd1;
      if (bus.r1_req && !bus.r1_gnt) perf_wait1_q <= perf_wait1_q + 32'd1;
    end
  end

  assign perf_gnt0  = perf_gnt0_q;
  assign perf_gnt1  = perf_gnt1_q;
  assign perf_wait0 = perf_wait0_q;
  assign perf_wait1 = perf_wait1_q;
`endif

endmodule
